// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a one-deep registered output and an optional
// accumulate-burst mode that folds several beat results into one output.
module logic_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             acc,
  input  logic [1:0]       fold,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_d;
  logic [WIDTH-1:0] accum, accum_d;
  logic [CNT_W-1:0] count, count_d, count_inc;
  logic [1:0]       fold_q, fold_d;
  logic [WIDTH-1:0] r, folded, out_d;
  logic [CNT_W-1:0] cnt_d;
  logic             accept, load_out;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    unique case (op)
      3'b000:  r = A & B;
      3'b001:  r = A | B;
      3'b010:  r = A ^ B;
      3'b011:  r = ~(A & B);
      3'b100:  r = ~(A | B);
      3'b101:  r = ~(A ^ B);
      3'b110:  r = ~A;
      default: r = A;
    endcase
  end

  // Fold code 11 is deliberately treated the same as AND.
  always_comb begin
    unique case (fold_q)
      2'b01:   folded = accum | r;
      2'b10:   folded = accum ^ r;
      default: folded = accum & r;
    endcase
  end

  assign count_inc = (count == CNT_MAX) ? count : count + CNT_ONE;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state;
    accum_d  = accum;
    count_d  = count;
    fold_d   = fold_q;
    load_out = 1'b0;
    out_d    = r;
    cnt_d    = CNT_ONE;
    if (accept) begin
      if (!acc) begin
        load_out = 1'b1;
      end else if (state == IDLE) begin
        accum_d = r;
        count_d = CNT_ONE;
        fold_d  = fold;
        if (last) load_out = 1'b1;
        else      state_d  = ACCUM;
      end else begin
        accum_d = folded;
        count_d = count_inc;
        if (last) begin
          load_out = 1'b1;
          out_d    = folded;
          cnt_d    = count_inc;
          state_d  = IDLE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      accum     <= '0;
      count     <= '0;
      fold_q    <= 2'b00;
      out       <= '0;
      cnt       <= '0;
      zero      <= 1'b1;
      ones      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state  <= state_d;
      accum  <= accum_d;
      count  <= count_d;
      fold_q <= fold_d;
      if (load_out) begin
        out       <= out_d;
        cnt       <= cnt_d;
        zero      <= (out_d == '0);
        ones      <= (out_d == '1);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and result width in bits.
REQ-002 Parameter CNT_W, default 8, SHALL set the beat-count width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL flag a valid input beat.
REQ-006 in_ready  output  1  SHALL flag that the block accepts a beat this cycle.
REQ-007 op  input  3  SHALL select the bitwise function.
REQ-008 A, B  input  WIDTH  SHALL carry the operands.
REQ-009 acc  input  1  SHALL mark the beat as part of an accumulate burst.
REQ-010 fold  input  2  SHALL select the burst fold function, sampled on the first burst beat.
REQ-011 last  input  1  SHALL mark the final beat of an accumulate burst.
REQ-012 out_valid  output  1  SHALL flag a valid result.
REQ-013 out_ready  input  1  SHALL flag that the consumer takes the result.
REQ-014 out  output  WIDTH  SHALL carry the result.
REQ-015 zero, ones  output  1 each  SHALL flag out all-0s and out all-1s.
REQ-016 cnt  output  CNT_W  SHALL carry the number of beats folded into out.

Function
REQ-017 Beat result r[i] SHALL be f_op(A[i],B[i]) for every bit i, independently.
- op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 pass A.
REQ-018 A beat SHALL be accepted exactly when in_valid && in_ready.
- in_ready = !out_valid || out_ready.
REQ-019 A non-accumulate beat (acc=0) SHALL load out=r and cnt=1, and set out_valid the next cycle; latency 1 cycle.
REQ-020 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-021 out, cnt, zero and ones SHALL be registered and SHALL hold stable while out_valid && !out_ready.
REQ-022 out_valid SHALL clear after a handshake that has no new result loaded in the same cycle.
REQ-023 The burst FSM SHALL have states IDLE and ACCUM.
REQ-024 An accepted acc=1 beat in IDLE SHALL do the following:
- load accum=r, count=1, fold_q=fold;
- if last=0, go to ACCUM and produce no output;
- if last=1, produce out=r, cnt=1 and stay in IDLE.
REQ-025 An accepted acc=1 beat in ACCUM SHALL update accum = accum g r and count = count+1.
- g is set by fold_q: 00 AND, 01 OR, 10 XOR, 11 treated as AND.
- if last=1, load out with the updated accum and cnt with the updated count, and return to IDLE.
REQ-026 Non-last burst beats SHALL be accepted whenever in_valid=1 and SHALL NOT touch the output register.
- in_ready still follows REQ-018.
REQ-027 An accepted acc=0 beat in ACCUM SHALL pass through per REQ-019 and leave accum, count, fold_q and state unchanged.
REQ-028 count SHALL saturate at 2^CNT_W-1; folding continues past saturation.
REQ-029 zero SHALL equal (out == 0) and ones SHALL equal (out == all 1s), both updated with out.
REQ-030 Unaccepted beats (in_valid=0 or in_ready=0) SHALL change no state.

Reset
REQ-031 rst_n=0 SHALL, asynchronously, force the following reset values:
- out=0, cnt=0, out_valid=0, zero=1, ones=0;
- state=IDLE, accum=0, count=0, fold_q=00.
REQ-032 A reset asserted mid-burst SHALL discard the partial accumulation; no result SHALL be emitted for that burst.
REQ-033 in_ready SHALL be 1 at reset.

Verification
REQ-034 The bench SHALL cover these scenarios, WIDTH=16:
- A=F0F0, B=FF00, acc=0, op swept 000..111 -> out = F000, FFF0, 0FF0, 0FFF, 000F, F00F, 0F0F, F0F0 respectively, one cycle after acceptance, cnt=1.
- Burst op=AND, fold=OR, 3 beats with r = 0001, 0002, 8000 -> a single out=8003 with cnt=3, emitted one cycle after the last beat; no out_valid during the burst.
- out_ready=0 held for 4 cycles with a result pending -> in_ready=0, and out/cnt stay stable; on release, one handshake, then the next beat flows.
- Single-beat burst (acc=1, last=1), op=XOR, A=B=1234 -> out=0000, zero=1, cnt=1.
- rst_n pulsed low after 2 beats of a burst -> outputs at reset values immediately; a following 1-beat burst op=OR, A=00FF, B=FF00 yields out=FFFF, ones=1, cnt=1.
- CNT_W=2 burst of 5 beats -> cnt=3 (saturated), and out equals the full 5-beat fold.
